// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: sensor channel states and light codes.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_QUAL = 2'd1,
    S_PRES = 2'd2,
    S_EXT  = 2'd3
  } sens_state_t;

  localparam logic [1:0] GREEN  = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] RED    = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_sensor_chan.sv
// One loop-detector channel: 2-flop synchroniser, debounce/extend FSM, registered presence.
// Optional stuck-high detection when SENSOR_FAULT_EN is defined.
module traffic_sensor_chan
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE     = 4,
  parameter int EXTEND       = 8,
  parameter int STUCK_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic pres_o,
  output logic fault_o
);

  localparam int CNT_W = $clog2(max_int(DEBOUNCE, EXTEND) + 1);

  logic             sync1_q, sync2_q;
  sens_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pres_q, pres_d;
  logic             fault_d;

  // NOTE: non-blocking so sync2_q captures the previous sync1_q; blocking would collapse the pair into one flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // NOTE: defaults assigned first so every path drives state_d/cnt_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (sync2_q) begin
          state_d = S_QUAL;
          cnt_d   = '0;
        end
      end
      S_QUAL: begin
        if (!sync2_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
          state_d = S_PRES;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PRES: begin
        if (!sync2_q) begin
          state_d = S_EXT;
          cnt_d   = '0;
        end
      end
      S_EXT: begin
        if (sync2_q) begin
          state_d = S_PRES;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(EXTEND - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    pres_d = (state_d == S_PRES) || (state_d == S_EXT) || fault_d;
  end

`ifdef SENSOR_FAULT_EN
  localparam int STK_W = $clog2(STUCK_CYCLES + 1);

  logic [STK_W-1:0] stuck_q, stuck_d;
  logic             fault_q;

  // Saturating run length of synced-high samples; fault latches on reaching the limit.
  always_comb begin
    stuck_d = '0;
    if (sync2_q) begin
      stuck_d = (stuck_q == STK_W'(STUCK_CYCLES)) ? stuck_q : stuck_q + STK_W'(1);
    end
    fault_d = fault_q | (sync2_q && (stuck_q == STK_W'(STUCK_CYCLES - 1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuck_q <= '0;
      fault_q <= 1'b0;
    end else begin
      stuck_q <= stuck_d;
      fault_q <= fault_d;
    end
  end

  assign fault_o = fault_q;
`else
  assign fault_d = 1'b0;
  assign fault_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pres_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pres_q  <= pres_d;
    end
  end

  assign pres_o = pres_q;

endmodule

// File: rtl/traffic_sensor.sv
// Two-approach vehicle detector front end (NS -> Ta, EW -> Tb); wiring only.
// Stuck-detector flags are active only when SENSOR_FAULT_EN is defined.
module traffic_sensor #(
  parameter int DEBOUNCE     = 4,
  parameter int EXTEND       = 8,
  parameter int STUCK_CYCLES = 1024
) (
  input  logic clk,
  input  logic Reset,
  input  logic RawA,
  input  logic RawB,
  output logic Ta,
  output logic Tb,
  output logic FaultA,
  output logic FaultB
);

  traffic_sensor_chan #(
    .DEBOUNCE    (DEBOUNCE),
    .EXTEND      (EXTEND),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_chan_a (
    .clk    (clk),
    .rst    (Reset),
    .raw_i  (RawA),
    .pres_o (Ta),
    .fault_o(FaultA)
  );

  traffic_sensor_chan #(
    .DEBOUNCE    (DEBOUNCE),
    .EXTEND      (EXTEND),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_chan_b (
    .clk    (clk),
    .rst    (Reset),
    .raw_i  (RawB),
    .pres_o (Tb),
    .fault_o(FaultB)
  );

endmodule
